// File: rtl/digit_entry_if.sv
// Button inputs and digit/cursor outputs shared by the entry controller and its user.
// The master drives the raw buttons; the slave (the controller) drives the display state.
interface digit_entry_if;
  logic        btnUp;
  logic        btnDown;
  logic        btnLeft;
  logic        btnRight;
  logic [3:0]  number;
  logic [3:0]  currLED;
  logic [15:0] digits;
  logic        update;

  modport master (
    output btnUp, btnDown, btnLeft, btnRight,
    input  number, currLED, digits, update
  );

  modport slave (
    input  btnUp, btnDown, btnLeft, btnRight,
    output number, currLED, digits, update
  );
endinterface

// File: rtl/digit_entry_controller.sv
// Four-button digit editor: sync + debounce + press detect per button, then a cursor
// over four stored BCD digits feeding the seven-segment driver.
module digit_entry_controller #(
  parameter int debounceBits   = 20,
  parameter int debounceCycles = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  digit_entry_if.slave  bus
);

  localparam logic [debounceBits-1:0] CNT_LAST = debounceBits'(debounceCycles - 1);
  localparam logic [debounceBits-1:0] CNT_ONE  = debounceBits'(1);

  // Button lane order: 0 up, 1 down, 2 right, 3 left
  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_RIGHT = 2;
  localparam int B_LEFT  = 3;

  logic [3:0]              raw;
  logic [3:0]              s1_p0;
  logic [3:0]              s2_p1;
  logic [3:0]              db_p2;
  logic [3:0]              db_prev_p2;
  logic [debounceBits-1:0] cnt_p2 [4];
  logic [3:0]              press;

  logic                    act_up;
  logic                    act_down;
  logic                    act_right;
  logic                    act_left;

  logic [3:0][3:0]         dig;
  logic [3:0]              cur_led;
  logic [3:0]              cur_num;
  logic                    upd;

  logic [3:0][3:0]         nxt_dig;
  logic [3:0]              nxt_led;
  logic [3:0]              nxt_num;
  logic                    nxt_upd;
  logic [1:0]              sel_idx;
  logic                    sel_ok;
  logic [3:0]              led_r;
  logic [3:0]              led_l;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
  endfunction

  function automatic logic [3:0] rot_right(input logic [3:0] led);
    return {led[0], led[3:1]};
  endfunction

  function automatic logic [3:0] rot_left(input logic [3:0] led);
    return {led[2:0], led[3]};
  endfunction

  function automatic logic [1:0] led_to_idx(input logic [3:0] led);
    logic [1:0] idx;
    idx = 2'd0;
    case (led)
      4'b1000: idx = 2'd0;
      4'b0100: idx = 2'd1;
      4'b0010: idx = 2'd2;
      4'b0001: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  assign raw = {bus.btnLeft, bus.btnRight, bus.btnDown, bus.btnUp};

  // Stage p0/p1: two-flop synchroniser; stage p2: debounce counter and previous level
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_p0      <= '0;
      s2_p1      <= '0;
      db_p2      <= '0;
      db_prev_p2 <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_p2[i] <= '0;
      end
    end else begin
      s1_p0      <= raw;
      s2_p1      <= s1_p0;
      db_prev_p2 <= db_p2;
      for (int i = 0; i < 4; i++) begin
        if (s2_p1[i] == db_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_LAST) begin
          db_p2[i]  <= s2_p1[i];
          cnt_p2[i] <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + CNT_ONE;
        end
      end
    end
  end

  assign press = db_p2 & ~db_prev_p2;

  // Fixed priority; losing pulses in the same cycle are simply dropped
  assign act_up    = press[B_UP];
  assign act_down  = press[B_DOWN]  & ~press[B_UP];
  assign act_right = press[B_RIGHT] & ~press[B_UP] & ~press[B_DOWN];
  assign act_left  = press[B_LEFT]  & ~press[B_UP] & ~press[B_DOWN] & ~press[B_RIGHT];

  assign sel_ok  = (cur_led == 4'b1000) || (cur_led == 4'b0100) ||
                   (cur_led == 4'b0010) || (cur_led == 4'b0001);
  assign sel_idx = led_to_idx(cur_led);
  assign led_r   = rot_right(cur_led);
  assign led_l   = rot_left(cur_led);

  always_comb begin
    nxt_dig = dig;
    nxt_led = cur_led;
    nxt_num = cur_num;
    nxt_upd = 1'b0;
    if (!sel_ok) begin
      nxt_led = 4'b1000;
      nxt_num = dig[0];
      nxt_upd = 1'b1;
    end else if (act_up) begin
      nxt_dig[sel_idx] = bcd_inc(dig[sel_idx]);
      nxt_num          = bcd_inc(dig[sel_idx]);
      nxt_upd          = 1'b1;
    end else if (act_down) begin
      nxt_dig[sel_idx] = bcd_dec(dig[sel_idx]);
      nxt_num          = bcd_dec(dig[sel_idx]);
      nxt_upd          = 1'b1;
    end else if (act_right) begin
      nxt_led = led_r;
      nxt_num = dig[led_to_idx(led_r)];
      nxt_upd = 1'b1;
    end else if (act_left) begin
      nxt_led = led_l;
      nxt_num = dig[led_to_idx(led_l)];
      nxt_upd = 1'b1;
    end
  end

  // Output stage: number always tracks the digit under the cursor after the action
  always_ff @(posedge clk) begin
    if (rst) begin
      dig     <= '0;
      cur_led <= 4'b1000;
      cur_num <= 4'd0;
      upd     <= 1'b0;
    end else begin
      dig     <= nxt_dig;
      cur_led <= nxt_led;
      cur_num <= nxt_num;
      upd     <= nxt_upd;
    end
  end

  assign bus.number  = cur_num;
  assign bus.currLED = cur_led;
  assign bus.digits  = {dig[0], dig[1], dig[2], dig[3]};
  assign bus.update  = upd;

endmodule
